// File: rtl/vga_scaled_window.sv
// VGA timing generator with a replicated image window: drives the image RAM address
// and realigns sync, enable and colour around the RAM read latency.
module vga_scaled_window #(
    parameter int          H_ACTIVE   = 640,
    parameter int          H_FP       = 16,
    parameter int          H_SYNC     = 96,
    parameter int          H_BP       = 48,
    parameter int          V_ACTIVE   = 480,
    parameter int          V_FP       = 10,
    parameter int          V_SYNC     = 2,
    parameter int          V_BP       = 33,
    parameter int          HS_POL     = 0,
    parameter int          VS_POL     = 0,
    parameter int          IMG_W      = 100,
    parameter int          IMG_H      = 100,
    parameter int          SCALE      = 2,
    parameter int          X0         = 0,
    parameter int          Y0         = 0,
    parameter int          RD_LAT     = 1,
    parameter int          COLOR_MODE = 0,
    parameter logic [7:0]  BORDER     = 8'h00,
    parameter int          ADDR_W     = 16
) (
    input  logic              clk_25Mhz,
    input  logic              rst_n,
    input  logic [7:0]        colorInput,
    output logic [ADDR_W-1:0] nextAddress,
    output logic              addr_valid,
    output logic              Hsync,
    output logic              Vsync,
    output logic              de,
    output logic              frame_start,
    output logic [7:0]        Red,
    output logic [7:0]        Green,
    output logic [7:0]        Blue,
    output logic              VGA_clk
);

    localparam int H_TOTAL  = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL  = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int HW       = $clog2(H_TOTAL);
    localparam int VW       = $clog2(V_TOTAL);
    localparam int H_START  = H_SYNC + H_BP;
    localparam int H_END    = H_START + H_ACTIVE;
    localparam int V_START  = V_SYNC + V_BP;
    localparam int V_END    = V_START + V_ACTIVE;
    localparam int WX_START = H_START + X0;
    localparam int WX_END   = (WX_START + IMG_W * SCALE < H_END) ? WX_START + IMG_W * SCALE : H_END;
    localparam int WY_START = V_START + Y0;
    localparam int WY_END   = (WY_START + IMG_H * SCALE < V_END) ? WY_START + IMG_H * SCALE : V_END;
    localparam int NSTG     = RD_LAT + 1;

    localparam logic              HS_ON    = 1'(HS_POL);
    localparam logic              VS_ON    = 1'(VS_POL);
    localparam logic [2:0]        SC_LAST  = 3'(SCALE - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);

    typedef struct packed {
        logic fs;
        logic win;
        logic de;
        logic vs;
        logic hs;
    } flags_t;

    logic [HW-1:0]     r_h_cnt;
    logic [VW-1:0]     r_v_cnt;
    logic [31:0]       w_h;
    logic [31:0]       w_v;
    logic              w_h_wrap;
    logic              w_v_wrap;
    logic              w_hwin;
    logic              w_vwin;
    logic              w_win;
    logic [2:0]        r_xsub;
    logic [2:0]        r_ysub;
    logic [ADDR_W-1:0] r_col;
    logic [ADDR_W-1:0] r_row_base;
    flags_t            w_stage0;
    flags_t            r_dly [NSTG];
    flags_t            w_out;
    logic [7:0]        r_pix;
    logic [7:0]        w_r_map;
    logic [7:0]        w_g_map;
    logic [7:0]        w_b_map;

    assign VGA_clk  = clk_25Mhz;
    assign w_h      = 32'(r_h_cnt);
    assign w_v      = 32'(r_v_cnt);
    assign w_h_wrap = (w_h == H_TOTAL - 1);
    assign w_v_wrap = (w_v == V_TOTAL - 1);

    always_ff @(posedge clk_25Mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_wrap) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + 1'b1;
        end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
        end
    end

    // Window bounds already include clipping against the active area.
    assign w_hwin = (w_h >= WX_START) && (w_h < WX_END);
    assign w_vwin = (w_v >= WY_START) && (w_v < WY_END);
    assign w_win  = w_hwin && w_vwin;

    assign w_stage0 = {(w_h == H_START) && (w_v == V_START),
                       w_win,
                       (w_h >= H_START) && (w_h < H_END) && (w_v >= V_START) && (w_v < V_END),
                       (w_v < V_SYNC),
                       (w_h < H_SYNC)};

    // Column/row tracked incrementally so the address needs only one adder.
    always_ff @(posedge clk_25Mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_xsub     <= '0;
            r_col      <= '0;
            r_ysub     <= '0;
            r_row_base <= '0;
        end else begin
            if (!w_hwin) begin
                r_xsub <= '0;
                r_col  <= '0;
            end else if (r_xsub == SC_LAST) begin
                r_xsub <= '0;
                r_col  <= r_col + 1'b1;
            end else begin
                r_xsub <= r_xsub + 1'b1;
            end

            if (w_h_wrap) begin
                if (w_v_wrap) begin
                    r_ysub     <= '0;
                    r_row_base <= '0;
                end else if (w_vwin) begin
                    if (r_ysub == SC_LAST) begin
                        r_ysub     <= '0;
                        r_row_base <= r_row_base + ROW_STEP;
                    end else begin
                        r_ysub <= r_ysub + 1'b1;
                    end
                end
            end
        end
    end

    assign addr_valid  = w_win;
    assign nextAddress = w_win ? (r_row_base + r_col) : '0;

    always_ff @(posedge clk_25Mhz or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NSTG; i++) r_dly[i] <= '0;
            r_pix <= '0;
        end else begin
            r_dly[0] <= w_stage0;
            for (int i = 1; i < NSTG; i++) r_dly[i] <= r_dly[i-1];
            r_pix <= colorInput;
        end
    end

    assign w_out       = r_dly[NSTG-1];
    assign Hsync       = w_out.hs ? HS_ON : ~HS_ON;
    assign Vsync       = w_out.vs ? VS_ON : ~VS_ON;
    assign de          = w_out.de;
    assign frame_start = w_out.fs;

    generate
        if (COLOR_MODE == 1) begin : g_rgb332
            assign w_r_map = {r_pix[7:5], r_pix[7:5], r_pix[7:6]};
            assign w_g_map = {r_pix[4:2], r_pix[4:2], r_pix[4:3]};
            assign w_b_map = {4{r_pix[1:0]}};
        end else begin : g_gray
            assign w_r_map = r_pix;
            assign w_g_map = r_pix;
            assign w_b_map = r_pix;
        end
    endgenerate

    always_comb begin
        Red   = '0;
        Green = '0;
        Blue  = '0;
        if (w_out.de) begin
            if (w_out.win) begin
                Red   = w_r_map;
                Green = w_g_map;
                Blue  = w_b_map;
            end else begin
                Red   = BORDER;
                Green = BORDER;
                Blue  = BORDER;
            end
        end
    end

endmodule

// File: tb/tb_vga_scaled_window.sv
// Directed bench: three instances on a reduced timing grid (54 clocks x 37 lines)
// covering gray/RGB332, window offsets, clipping, SCALE 1 and 2, RD_LAT 0/1/3 and reset.
module tb_vga_scaled_window;

    localparam int FRAME = 54 * 37;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    // Instance A: gray, window at origin, SCALE 2, RD_LAT 1
    logic [7:0]  a_color;
    logic [15:0] a_addr;
    logic        a_av, a_hs, a_vs, a_de, a_fs, a_vclk;
    logic [7:0]  a_r, a_g, a_b;
    // Instance B: RGB332, offset window clipped on the right, RD_LAT 3
    logic [7:0]  b_color, b_q1, b_q2;
    logic [7:0]  b_addr;
    logic        b_av, b_hs, b_vs, b_de, b_fs, b_vclk;
    logic [7:0]  b_r, b_g, b_b;
    // Instance C: SCALE 1, RD_LAT 0, active-high syncs
    logic [7:0]  c_color;
    logic [4:0]  c_addr;
    logic        c_av, c_hs, c_vs, c_de, c_fs, c_vclk;
    logic [7:0]  c_r, c_g, c_b;

    vga_scaled_window #(
        .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(4),
        .V_ACTIVE(30), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .HS_POL(0), .VS_POL(0), .IMG_W(10), .IMG_H(10), .SCALE(2),
        .X0(0), .Y0(0), .RD_LAT(1), .COLOR_MODE(0), .BORDER(8'h5A), .ADDR_W(16)
    ) u_a (
        .clk_25Mhz(clk), .rst_n(rst_n), .colorInput(a_color), .nextAddress(a_addr),
        .addr_valid(a_av), .Hsync(a_hs), .Vsync(a_vs), .de(a_de), .frame_start(a_fs),
        .Red(a_r), .Green(a_g), .Blue(a_b), .VGA_clk(a_vclk)
    );

    vga_scaled_window #(
        .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(4),
        .V_ACTIVE(30), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .HS_POL(0), .VS_POL(0), .IMG_W(10), .IMG_H(10), .SCALE(2),
        .X0(25), .Y0(5), .RD_LAT(3), .COLOR_MODE(1), .BORDER(8'h40), .ADDR_W(8)
    ) u_b (
        .clk_25Mhz(clk), .rst_n(rst_n), .colorInput(b_color), .nextAddress(b_addr),
        .addr_valid(b_av), .Hsync(b_hs), .Vsync(b_vs), .de(b_de), .frame_start(b_fs),
        .Red(b_r), .Green(b_g), .Blue(b_b), .VGA_clk(b_vclk)
    );

    vga_scaled_window #(
        .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(4),
        .V_ACTIVE(30), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .HS_POL(1), .VS_POL(1), .IMG_W(8), .IMG_H(4), .SCALE(1),
        .X0(3), .Y0(2), .RD_LAT(0), .COLOR_MODE(0), .BORDER(8'h00), .ADDR_W(5)
    ) u_c (
        .clk_25Mhz(clk), .rst_n(rst_n), .colorInput(c_color), .nextAddress(c_addr),
        .addr_valid(c_av), .Hsync(c_hs), .Vsync(c_vs), .de(c_de), .frame_start(c_fs),
        .Red(c_r), .Green(c_g), .Blue(c_b), .VGA_clk(c_vclk)
    );

    // RAM models: A returns addr[7:0] after 1 clock, B returns addr^0xAE after 3, C is combinational
    always_ff @(posedge clk) begin
        a_color <= a_addr[7:0];
        b_q1    <= b_addr ^ 8'hAE;
        b_q2    <= b_q1;
        b_color <= b_q2;
    end
    assign c_color = {3'b000, c_addr};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // Advance to the cycle where the counters have made n steps since reset release.
    task automatic run_to(input int n);
        if (cyc < n) begin
            while (cyc < n) begin
                @(posedge clk);
                cyc++;
            end
            #1;
        end
    endtask

    initial begin
        int hs_lo, vs_lo, de_hi, fs_cnt, fs_bad, fs_prev, fs_gap, c_hs_hi, c_fs_cnt, tgt;

        repeat (3) @(posedge clk);
        #1;
        check("rst_a_hs", 32'(a_hs), 1);
        check("rst_a_vs", 32'(a_vs), 1);
        check("rst_a_de", 32'(a_de), 0);
        check("rst_a_fs", 32'(a_fs), 0);
        check("rst_a_red", 32'(a_r), 0);
        check("rst_a_addr", 32'(a_addr), 0);
        check("rst_a_av", 32'(a_av), 0);
        check("rst_c_hs", 32'(c_hs), 0);
        check("rst_c_vs", 32'(c_vs), 0);
        check("rst_b_blue", 32'(b_b), 0);
        check("vga_clk_a", 32'(a_vclk), 1);
        check("vga_clk_b", 32'(b_vclk), 1);
        check("vga_clk_c", 32'(c_vclk), 1);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;

        run_to(1);    check("a_hs_fill", 32'(a_hs), 1);
        run_to(2);    check("a_hs_first", 32'(a_hs), 0);
        run_to(31);   check("c_vs_high", 32'(c_vs), 1);
        run_to(86);   check("a_vs_line1", 32'(a_vs), 0);
        run_to(140);  check("a_vs_line2", 32'(a_vs), 1);
        run_to(280);  check("a_addr_x0y0", 32'(a_addr), 0);
                      check("a_av_x0y0", 32'(a_av), 1);
        run_to(282);  check("a_red_x0", 32'(a_r), 0);
                      check("a_de_x0", 32'(a_de), 1);
                      check("a_fs_x0", 32'(a_fs), 1);
        run_to(283);  check("a_fs_x1", 32'(a_fs), 0);
        run_to(284);  check("a_red_x2", 32'(a_r), 1);
        run_to(285);  check("a_green_x3", 32'(a_g), 1);
        run_to(301);  check("a_red_x19", 32'(a_r), 9);
        run_to(302);  check("a_border_x20", 32'(a_r), 'h5A);
        run_to(338);  check("a_red_y1x2", 32'(a_r), 1);
        run_to(388);  check("a_addr_y2x0", 32'(a_addr), 10);
        run_to(390);  check("a_red_y2x0", 32'(a_r), 10);
        run_to(391);  check("c_av_x3", 32'(c_av), 1);
                      check("c_addr_x3", 32'(c_addr), 0);
        run_to(393);  check("c_red_x4", 32'(c_r), 1);
        run_to(398);  check("c_addr_x10", 32'(c_addr), 7);
        run_to(399);  check("c_red_x10", 32'(c_r), 7);
                      check("c_av_x11", 32'(c_av), 0);
        run_to(400);  check("c_de_x11", 32'(c_de), 1);
                      check("c_border_x11", 32'(c_r), 0);
        run_to(525);  check("b_border_above", 32'(b_r), 'h40);
        run_to(541);  check("c_hs_active", 32'(c_hs), 1);
        run_to(542);  check("a_hs_line10", 32'(a_hs), 0);
        run_to(547);  check("c_hs_idle", 32'(c_hs), 0);
                      check("a_de_porch", 32'(a_de), 0);
                      check("a_red_porch", 32'(a_r), 0);
        run_to(553);  check("b_de_pre", 32'(b_de), 0);
                      check("b_red_pre", 32'(b_r), 0);
        run_to(554);  check("b_de_rise", 32'(b_de), 1);
                      check("b_red_rise", 32'(b_r), 'h40);
        run_to(560);  check("c_addr_last", 32'(c_addr), 31);
        run_to(561);  check("c_red_last", 32'(c_r), 'h1F);
        run_to(574);  check("b_av_x24", 32'(b_av), 0);
        run_to(575);  check("b_av_x25", 32'(b_av), 1);
                      check("b_addr_x25", 32'(b_addr), 0);
        run_to(578);  check("b_border_x24", 32'(b_r), 'h40);
        run_to(579);  check("b_red_p0", 32'(b_r), 'hB6);
                      check("b_green_p0", 32'(b_g), 'h6D);
                      check("b_blue_p0", 32'(b_b), 'hAA);
        run_to(581);  check("b_blue_p1", 32'(b_b), 'hFF);
        run_to(589);  check("b_addr_clip", 32'(b_addr), 7);
        run_to(593);  check("b_green_p7", 32'(b_g), 'h49);
                      check("b_blue_p7", 32'(b_b), 'h55);
        run_to(594);  check("b_de_fp", 32'(b_de), 0);
                      check("b_red_fp", 32'(b_r), 0);
        run_to(607);  check("c_av_below", 32'(c_av), 0);
        run_to(683);  check("b_addr_row1", 32'(b_addr), 10);
        run_to(689);  check("b_green_p11", 32'(b_g), 'h24);
                      check("b_blue_p11", 32'(b_b), 'h55);
        run_to(1325); check("a_addr_last", 32'(a_addr), 99);
        run_to(1327); check("a_red_last", 32'(a_r), 'h63);
        run_to(1360); check("a_av_below", 32'(a_av), 0);
                      check("a_addr_below", 32'(a_addr), 0);
        run_to(1362); check("a_border_below", 32'(a_r), 'h5A);
        run_to(1615); check("b_addr_max", 32'(b_addr), 97);
        run_to(1655); check("b_av_below", 32'(b_av), 0);

        hs_lo = 0; vs_lo = 0; de_hi = 0; fs_cnt = 0; fs_bad = 0;
        fs_prev = -1; fs_gap = -1; c_hs_hi = 0; c_fs_cnt = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(posedge clk);
            cyc++;
            #1;
            if (a_hs === 1'b0) hs_lo++;
            if (a_vs === 1'b0) vs_lo++;
            if (a_de === 1'b1) de_hi++;
            if (c_hs === 1'b1) c_hs_hi++;
            if (c_fs === 1'b1) c_fs_cnt++;
            if (a_fs === 1'b1) begin
                fs_cnt++;
                if (a_de !== 1'b1) fs_bad++;
                if (fs_prev >= 0) fs_gap = cyc - fs_prev;
                fs_prev = cyc;
            end
        end
        check("a_hsync_count", 32'(hs_lo), 444);
        check("a_vsync_count", 32'(vs_lo), 216);
        check("a_de_count", 32'(de_hi), 2400);
        check("a_fs_count", 32'(fs_cnt), 2);
        check("a_fs_without_de", 32'(fs_bad), 0);
        check("a_fs_period", 32'(fs_gap), FRAME);
        check("c_hsync_count", 32'(c_hs_hi), 444);
        check("c_fs_count", 32'(c_fs_cnt), 2);

        // Mid-frame reset at counter state v=15, h=20
        tgt = cyc - (cyc % FRAME) + 830;
        if (tgt <= cyc) tgt += FRAME;
        run_to(tgt);
        check("a_red_pre_rst", 32'(a_r), 'h36);
        check("a_addr_pre_rst", 32'(a_addr), 55);
        rst_n = 1'b0;
        #1;
        check("a_red_in_rst", 32'(a_r), 0);
        check("a_de_in_rst", 32'(a_de), 0);
        check("a_hs_in_rst", 32'(a_hs), 1);
        check("a_addr_in_rst", 32'(a_addr), 0);
        check("a_av_in_rst", 32'(a_av), 0);
        check("c_hs_in_rst", 32'(c_hs), 0);
        @(posedge clk);
        #1;
        check("a_addr_hold_rst", 32'(a_addr), 0);
        check("a_vs_hold_rst", 32'(a_vs), 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        run_to(1);    check("a_hs_refill", 32'(a_hs), 1);
        run_to(2);    check("a_hs_restart", 32'(a_hs), 0);
        fs_cnt = 0;
        while (cyc < 281) begin
            @(posedge clk);
            cyc++;
            #1;
            if (a_fs === 1'b1) fs_cnt++;
        end
        check("a_fs_early", 32'(fs_cnt), 0);
        run_to(282);  check("a_fs_restart", 32'(a_fs), 1);
                      check("a_de_restart", 32'(a_de), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
